// File: rtl/cacheline_arbiter.sv
// Fixed-priority (dcache > icache > prefetch), non-preemptive arbiter onto one cacheline pmem port.
// Define ARB_PF_STARVE_EN to force a prefetch grant after PF_STARVE_LIMIT consecutive demand grants.
module cacheline_arbiter #(
    parameter int unsigned PF_STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    input  logic         pf_read,
    input  logic [31:0]  pf_address,
    output logic [255:0] pf_rdata,
    output logic         pf_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    typedef enum logic [2:0] {IDLE, BUSY_D, BUSY_I, BUSY_P, DONE} state_t;
    typedef enum logic [1:0] {CL_D, CL_I, CL_P} client_t;

    state_t       state_q, state_d;
    client_t      client_q, client_d;
    logic         write_q, write_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] wdata_q, wdata_d;
    logic [255:0] i_rdata_q, i_rdata_d;
    logic [255:0] d_rdata_q, d_rdata_d;
    logic [255:0] pf_rdata_q, pf_rdata_d;
    logic         d_req;
    logic         busy;
    logic         pf_force;

    assign d_req = d_read | d_write;
    assign busy  = (state_q == BUSY_D) || (state_q == BUSY_I) || (state_q == BUSY_P);

`ifdef ARB_PF_STARVE_EN
    localparam logic [3:0] STARVE_MAX = 4'(PF_STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    assign pf_force = (state_q == IDLE) && pf_read && (starve_q == STARVE_MAX);

    // Counts demand grants that bypassed a waiting prefetch; any prefetch grant or idle pf_read clears it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (!pf_read || pf_force || (!d_req && !i_read)) begin
                starve_d = '0;
            end else if (starve_q < STARVE_MAX) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (PF_STARVE_LIMIT != 0);
    assign pf_force            = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        client_d   = client_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        pf_rdata_d = pf_rdata_q;
        case (state_q)
            IDLE: begin
                if (pf_force) begin
                    state_d  = BUSY_P;
                    client_d = CL_P;
                    write_d  = 1'b0;
                    addr_d   = pf_address;
                end else if (d_req) begin
                    // A simultaneous read+write from the dcache is served as the writeback.
                    state_d  = BUSY_D;
                    client_d = CL_D;
                    write_d  = d_write;
                    addr_d   = d_address;
                    if (d_write) begin
                        wdata_d = d_wdata;
                    end
                end else if (i_read) begin
                    state_d  = BUSY_I;
                    client_d = CL_I;
                    write_d  = 1'b0;
                    addr_d   = i_address;
                end else if (pf_read) begin
                    state_d  = BUSY_P;
                    client_d = CL_P;
                    write_d  = 1'b0;
                    addr_d   = pf_address;
                end
            end
            BUSY_D, BUSY_I, BUSY_P: begin
                if (pmem_resp) begin
                    state_d = DONE;
                    case (client_q)
                        CL_D:    d_rdata_d  = pmem_rdata;
                        CL_I:    i_rdata_d  = pmem_rdata;
                        default: pf_rdata_d = pmem_rdata;
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            client_q   <= CL_D;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            pf_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            client_q   <= client_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            pf_rdata_q <= pf_rdata_d;
        end
    end

    assign pmem_read    = busy & ~write_q;
    assign pmem_write   = busy & write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign pf_rdata     = pf_rdata_q;
    assign d_resp       = (state_q == DONE) && (client_q == CL_D);
    assign i_resp       = (state_q == DONE) && (client_q == CL_I);
    assign pf_resp      = (state_q == DONE) && (client_q == CL_P);

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: transaction-level grant/response model, decoupled negedge monitor.
module tb_cacheline_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic i_read, d_read, d_write, pf_read, pmem_resp;
    logic [31:0] i_address, d_address, pf_address;
    logic [255:0] d_wdata, pmem_rdata;
    logic [255:0] i_rdata, d_rdata, pf_rdata, pmem_wdata;
    logic i_resp, d_resp, pf_resp, pmem_read, pmem_write;
    logic [31:0] pmem_address;

    cacheline_arbiter #(.PF_STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pf_read(pf_read), .pf_address(pf_address), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

`ifdef ARB_PF_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif
    localparam int LIMIT = 2;
    localparam int CD = 0, CI = 1, CP = 2;
    localparam int ST_IDLE = 0, ST_REQ = 1, ST_GNT = 2;
    localparam int M_IDLE = 0, M_FLIGHT = 1, M_DONE = 2;

    typedef struct {
        int           client;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int           cyc;
    } exp_t;

    exp_t grant_q[$];
    exp_t resp_q[$];
    int   glog[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   m_st = M_IDLE, m_client = 0, m_starve = 0;
    int   mem_cnt = 0, mem_lat = 0, mem_resp_cyc = -1;
    bit   mem_start = 0, mem_fixed_en = 0, rand_en = 0, hold_en = 0;
    logic [255:0] mem_fixed = '0;
    int   cst[3], cool[3];
    bit   rel[3];
    int   exp_ord[6];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, want);
        end
    endtask

    task automatic fail_evt(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [255:0] mem_data(input logic [31:0] a);
        if (mem_fixed_en) return mem_fixed;
        return {a, ~a, a ^ 32'h5a5a_5a5a, a + 32'd1, a, 32'hc0de_0000 | a[15:0], ~a + 32'd7, a};
    endfunction

    function automatic logic [31:0] rand_line();
        logic [31:0] a;
        a = $urandom();
        return a & 32'hffff_ffe0;
    endfunction

    task automatic set_lvl(input int c, input bit rd, input bit wr);
        case (c)
            CD: begin d_read = rd; d_write = wr; end
            CI: i_read = rd;
            default: pf_read = rd;
        endcase
    endtask

    task automatic req(input int c, input logic [31:0] a, input bit rd, input bit wr, input logic [255:0] wd);
        cst[c] = ST_REQ;
        case (c)
            CD: begin d_address = a; d_wdata = wd; end
            CI: i_address = a;
            default: pf_address = a;
        endcase
        set_lvl(c, rd, wr);
    endtask

    // Transaction-level reference: what the arbiter must do at this clock edge.
    task automatic model_edge();
        exp_t e;
        int   w;
        bit   dreq, anyr, force_pf;
        if (rst) begin
            m_st = M_IDLE; m_starve = 0; mem_cnt = 0; mem_start = 0;
            resp_q.delete();
            for (int c = 0; c < 3; c++) begin cst[c] = ST_IDLE; rel[c] = 0; cool[c] = 0; end
            return;
        end
        case (m_st)
            M_IDLE: begin
                dreq = d_read | d_write;
                anyr = dreq | i_read | pf_read;
                if (!pf_read) m_starve = 0;
                if (anyr) begin
                    force_pf = STARVE_EN && pf_read && (m_starve == LIMIT);
                    if (force_pf) w = CP;
                    else if (dreq) w = CD;
                    else if (i_read) w = CI;
                    else w = CP;
                    if (w == CP) m_starve = 0;
                    else if (pf_read && m_starve < LIMIT) m_starve++;
                    e.client = w;
                    e.wr     = (w == CD) && d_write;
                    e.addr   = (w == CD) ? d_address : (w == CI) ? i_address : pf_address;
                    e.wdata  = d_wdata;
                    e.rdata  = mem_data(e.addr);
                    e.cyc    = cyc;
                    grant_q.push_back(e);
                    resp_q.push_back(e);
                    glog.push_back(w);
                    m_st = M_FLIGHT; m_client = w; mem_start = 1; cst[w] = ST_GNT;
                end
            end
            M_FLIGHT: begin
                if (pmem_resp) begin
                    m_st = M_DONE; mem_resp_cyc = cyc; rel[m_client] = 1;
                end
            end
            default: m_st = M_IDLE;
        endcase
    endtask

    task automatic drive();
        pmem_resp  = 1'b0;
        pmem_rdata = rand256();
        if (mem_start) begin
            mem_start = 0;
            mem_cnt   = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 5));
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = mem_data(pmem_address);
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (rel[c]) begin
                rel[c] = 0; cst[c] = ST_IDLE; cool[c] = 1;
                if (!hold_en) set_lvl(c, 0, 0);
            end else if (cool[c] > 0) begin
                cool[c]--;
            end else if (rand_en && cst[c] == ST_IDLE && $urandom_range(0, 3) == 0) begin
                if (c == CD) begin
                    int k;
                    k = $urandom_range(0, 2);
                    req(CD, rand_line(), k != 1, k != 0, rand256());
                end else begin
                    req(c, rand_line(), 1, 0, '0);
                end
            end else if (rand_en && cst[c] == ST_GNT) begin
                if ($urandom_range(0, 3) == 0) set_lvl(c, 0, 0);
                if ($urandom_range(0, 1) == 1) begin
                    case (c)
                        CD: begin d_address = rand_line(); d_wdata = rand256(); end
                        CI: i_address = rand_line();
                        default: pf_address = rand_line();
                    endcase
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        drive();
    endtask

    task automatic run_until_idle(input string nm, input int maxc);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < maxc) begin
            step();
            n++;
            done = (m_st == M_IDLE) && (cst[0] == ST_IDLE) && (cst[1] == ST_IDLE) && (cst[2] == ST_IDLE);
        end
        if (!done) fail_evt({nm, "_timeout"});
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_i_resp"}, i_resp, 0);
        check({nm, "_d_resp"}, d_resp, 0);
        check({nm, "_pf_resp"}, pf_resp, 0);
        check({nm, "_pmem_read"}, pmem_read, 0);
        check({nm, "_pmem_write"}, pmem_write, 0);
        check({nm, "_pmem_address"}, pmem_address, 0);
        check({nm, "_pmem_wdata"}, pmem_wdata, 0);
        check({nm, "_i_rdata"}, i_rdata, 0);
        check({nm, "_d_rdata"}, d_rdata, 0);
        check({nm, "_pf_rdata"}, pf_rdata, 0);
    endtask

    // Monitor: every pmem transaction start and every client response is popped and compared.
    bit prev_strobe = 0;
    logic [31:0] cur_addr = '0;
    logic [255:0] cur_wdata = '0;
    always @(negedge clk) begin
        bit strobe;
        int nresp, act_c;
        exp_t e;
        logic [255:0] act_rd;
        strobe = (pmem_read === 1'b1) || (pmem_write === 1'b1);
        if (strobe && !prev_strobe) begin
            if (grant_q.size() == 0) begin
                fail_evt("unexpected_grant");
            end else begin
                e = grant_q.pop_front();
                check("grant_addr", pmem_address, e.addr);
                check("grant_op", {pmem_write, pmem_read}, e.wr ? 2'd2 : 2'd1);
                if (e.wr) check("grant_wdata", pmem_wdata, e.wdata);
                check("grant_cycle", cyc, e.cyc);
                cur_addr  = pmem_address;
                cur_wdata = pmem_wdata;
            end
        end else if (strobe) begin
            check("addr_stable", pmem_address, cur_addr);
            check("wdata_stable", pmem_wdata, cur_wdata);
        end
        prev_strobe = strobe;
        nresp = int'(d_resp === 1'b1) + int'(i_resp === 1'b1) + int'(pf_resp === 1'b1);
        if (nresp > 1) fail_evt("multiple_resp");
        if (nresp >= 1) begin
            act_c  = (d_resp === 1'b1) ? CD : (i_resp === 1'b1) ? CI : CP;
            act_rd = (act_c == CD) ? d_rdata : (act_c == CI) ? i_rdata : pf_rdata;
            if (resp_q.size() == 0) begin
                fail_evt("unexpected_resp");
            end else begin
                e = resp_q.pop_front();
                check("resp_client", act_c, e.client);
                if (!e.wr) check("resp_rdata", act_rd, e.rdata);
                check("resp_strobe_low", {pmem_write, pmem_read}, 2'd0);
                check("resp_cycle", cyc, mem_resp_cyc);
            end
        end
    end

    initial begin
        rst = 1; i_read = 0; d_read = 0; d_write = 0; pf_read = 0; pmem_resp = 0;
        i_address = '0; d_address = '0; pf_address = '0; d_wdata = '0; pmem_rdata = '0;
        for (int c = 0; c < 3; c++) begin cst[c] = ST_IDLE; cool[c] = 0; rel[c] = 0; end
        for (int k = 0; k < 6; k++) exp_ord[k] = (STARVE_EN && (k % 3 == 2)) ? CP : CD;

        repeat (2) step();
        @(negedge clk);
        check_zero("reset");
        rst = 0;

        // Single icache read, fixed 0xAA pattern, 4-cycle memory.
        mem_fixed_en = 1; mem_fixed = {32{8'haa}}; mem_lat = 4;
        step();
        req(CI, 32'h0000_1000, 1, 0, '0);
        run_until_idle("t1", 50);
        check("t1_rdata_held", i_rdata, {32{8'haa}});
        mem_fixed_en = 0;

        // Writeback beats a simultaneous prefetch.
        glog.delete();
        req(CD, 32'h0000_2000, 0, 1, {32{8'h55}});
        req(CP, 32'h0000_2020, 1, 0, '0);
        run_until_idle("t2", 60);
        check("t2_ngrants", glog.size(), 2);
        if (glog.size() == 2) begin
            check("t2_first", glog[0], CD);
            check("t2_second", glog[1], CP);
        end

        // Three-way contention.
        glog.delete(); mem_lat = 2;
        req(CD, 32'h0000_7000, 1, 0, '0);
        req(CI, 32'h0000_7100, 1, 0, '0);
        req(CP, 32'h0000_7200, 1, 0, '0);
        run_until_idle("t3", 80);
        check("t3_ngrants", glog.size(), 3);
        if (glog.size() == 3) begin
            check("t3_order0", glog[0], CD);
            check("t3_order1", glog[1], CI);
            check("t3_order2", glog[2], CP);
        end

        // Reset in the middle of an icache transaction, then a stray pmem_resp.
        mem_lat = 5;
        req(CI, 32'h0000_3000, 1, 0, '0);
        begin
            int n;
            n = 0;
            while (m_st != M_FLIGHT && n < 10) begin step(); n++; end
            if (m_st != M_FLIGHT) fail_evt("t4_grant_timeout");
        end
        step();
        rst = 1;
        step();
        rst = 0; i_read = 0;
        @(negedge clk);
        check_zero("t4_rst");
        step();
        pmem_resp = 1; pmem_rdata = rand256();
        step();
        repeat (2) step();
        @(negedge clk);
        check("t4_stray_read", pmem_read, 0);
        check("t4_stray_write", pmem_write, 0);
        check("t4_stray_iresp", i_resp, 0);
        mem_lat = 1;
        req(CI, 32'h0000_4000, 1, 0, '0);
        run_until_idle("t4_after", 40);

        // Continuous dcache and prefetch demand.
        glog.delete(); hold_en = 1;
        req(CD, 32'h0000_5000, 1, 0, '0);
        req(CP, 32'h0000_6000, 1, 0, '0);
        begin
            int n;
            n = 0;
            while (glog.size() < 6 && n < 200) begin step(); n++; end
            if (glog.size() < 6) fail_evt("t5_timeout");
        end
        d_read = 0; pf_read = 0; hold_en = 0;
        for (int c = 0; c < 3; c++) if (c != m_client || m_st == M_IDLE) cst[c] = ST_IDLE;
        for (int k = 0; k < 6 && k < glog.size(); k++) check($sformatf("t5_order%0d", k), glog[k], exp_ord[k]);
        run_until_idle("t5_drain", 40);

        // Randomized traffic.
        mem_lat = 0; rand_en = 1;
        repeat (3000) step();
        rand_en = 0;
        run_until_idle("rand_drain", 1000);
        repeat (3) step();
        @(negedge clk);
        check("grant_q_left", grant_q.size(), 0);
        check("resp_q_left", resp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Arbitrates cacheline-granular memory requests from three clients (icache, dcache, next-line prefetcher) onto the single physical-memory port (cacheline adaptor).
- Sits directly downstream of the prefetcher's pf_read/pf_address/pf_rdata/pf_resp port, and between the L1 caches and pmem.
- Non-preemptive: one transaction in flight at a time, with fixed priority dcache > icache > prefetch.

Parameters:
- PF_STARVE_LIMIT, 8, consecutive demand grants while pf_read is pending before the prefetcher is forced to the front (used only with ARB_PF_STARVE_EN).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_read  input  1  icache line read request (level, held until i_resp)
- i_address  input  32  icache line address
- i_rdata  output  256  icache read data
- i_resp  output  1  icache completion pulse
- d_read  input  1  dcache line read request
- d_write  input  1  dcache line writeback request
- d_address  input  32  dcache line address
- d_wdata  input  256  dcache writeback data
- d_rdata  output  256  dcache read data
- d_resp  output  1  dcache completion pulse
- pf_read  input  1  prefetcher line read request
- pf_address  input  32  prefetch line address
- pf_rdata  output  256  prefetch read data
- pf_resp  output  1  prefetch completion pulse
- pmem_read  output  1  memory read strobe
- pmem_write  output  1  memory write strobe
- pmem_address  output  32  memory line address
- pmem_wdata  output  256  memory write data
- pmem_rdata  input  256  memory read data
- pmem_resp  input  1  memory completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state goes to IDLE. All outputs are 0: resp pulses, pmem_read/pmem_write, pmem_address, pmem_wdata and all rdata buses. The starve counter is 0.
- States: IDLE, BUSY_D, BUSY_I, BUSY_P, DONE.
- IDLE:
  - Sample requests and pick the winner by priority: d_read|d_write, then i_read, then pf_read.
  - On the clock edge, latch the winner's address (and d_wdata for d_write), record the winner and the op, and move to BUSY_x.
  - If there are no requests, stay in IDLE.
- BUSY_x:
  - pmem_read or pmem_write is asserted from the first BUSY cycle. This gives 1-cycle grant latency: request seen at edge t, pmem strobe high at t+1.
  - pmem_address and pmem_wdata are stable from the latched registers for the whole transaction.
  - Stay in BUSY_x until pmem_resp, then go to DONE.
- pmem_resp edge:
  - Latch pmem_rdata into the granted client's rdata register.
  - pmem strobes deassert the next cycle.
- DONE:
  - The granted client's resp is high for exactly this one cycle; its rdata is valid here and held until that client's next completion.
  - All requests are ignored. Next state is IDLE.
  - Clients must drop their request in the cycle after resp, so IDLE then sees fresh requests only.
- d_read and d_write both high: treated as a write.
- Simultaneous requests: the losers keep their requests asserted and are served in later IDLE cycles. The minimum turnaround between back-to-back transactions is 2 idle cycles (DONE, IDLE).
- Request changes while BUSY: address/data changes are ignored (latched values are used). A request that deasserts mid-transaction still receives its resp.
- pmem_resp in IDLE or DONE: ignored, no state change.
- Reset during BUSY: return to IDLE, strobes drop immediately, the transaction is abandoned, and no resp is issued.
- Starve counter (when the feature is enabled), 4 bits, saturating at PF_STARVE_LIMIT:
  - Increments on each demand grant made while pf_read=1.
  - Clears on a prefetch grant, or whenever pf_read=0 in IDLE.

Optional Feature:
- Macro: ARB_PF_STARVE_EN.
- Defined: when the starve counter equals PF_STARVE_LIMIT and pf_read=1 in IDLE, the prefetcher wins over both demand clients for that one grant; the counter then clears.
- Undefined: strict priority. The prefetcher may starve indefinitely, no counter logic is instantiated, and PF_STARVE_LIMIT is unused.

Test Plan:
- Reset, then i_read=1, i_address=0x0000_1000; memory returns pmem_rdata=0xAA..AA after 4 cycles.
  - Expect pmem_read=1 and pmem_address=0x1000 one cycle after the request.
  - Expect i_resp pulsing for one cycle with i_rdata=0xAA..AA, and pmem_read low in the DONE cycle.
- d_write=1, d_address=0x2000, d_wdata=0x55..55, with pf_read=1 in the same cycle.
  - Expect the write to go first (pmem_write=1, pmem_wdata=0x55..55) and d_resp.
  - The prefetch at 0x2020 is then granted 2 cycles after DONE, and pf_resp returns pf_rdata.
- d_read, i_read and pf_read all high at once.
  - Expect grant order d, i, pf, each with exactly one resp pulse and no overlapping pmem strobes.
- Assert rst mid-BUSY_I.
  - Expect all outputs 0 on the next cycle and no i_resp.
  - A stray pmem_resp arriving afterwards causes no state change.
- With ARB_PF_STARVE_EN and PF_STARVE_LIMIT=2: hold d_read and pf_read high continuously.
  - Expect grant order d, d, pf, d, d, pf.
  - Without the macro: d only.
